// File: rtl/md_unit.sv
// md_unit: multi-cycle MIPS multiply/divide unit with HI/LO registers and stall-request busy flag
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0] res_hi, res_lo, squo, srem;
  logic [63:0] sprod, uprod, res;
  logic launch, commit, idle_start, ovf;
  assign idle_start = (state == IDLE) && start;
  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod = {32'h0, a} * {32'h0, b};
  assign ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
  assign squo = $signed(a) / $signed(b);
  assign srem = $signed(a) % $signed(b);
  // Result captured at launch; a zero divisor re-commits the current HI/LO so they appear unchanged
  always_comb begin
    res = md_op == 3'd0 ? sprod :
          md_op == 3'd1 ? uprod :
          b == 32'h0    ? {hi, lo} :
          md_op == 3'd2 ? (ovf ? {32'h0, 32'h8000_0000} : {srem, squo}) :
                          {a % b, a / b};
  end
  // Next state: launch on an idle mult/div start, return to IDLE on the final busy cycle
  always_comb begin
    launch = idle_start && !md_op[2];
    commit = (state == RUN) && (cnt == CW'(1));
    state_nxt = launch ? RUN : commit ? IDLE : state;
  end
  // State, countdown, shadow result and architectural HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nxt;
      busy  <= state_nxt == RUN;
      if (launch) begin
        cnt <= md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        {res_hi, res_lo} <= res;
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
      end
      if (commit) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (idle_start && md_op == 3'd4) begin
        hi <= a;
      end else if (idle_start && md_op == 3'd5) begin
        lo <= a;
      end
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized self-checking bench for md_unit against an arithmetic reference model
module tb_md_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [2:0] md_op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic busy;
  logic [31:0] hi, lo;
  int vectors = 0, miscompares = 0;
  logic [31:0] ref_hi = '0, ref_lo = '0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: new {hi,lo} computed with 64-bit integer arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x, y, h, l);
    longint sx, sy, q, r, p;
    longint unsigned up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      3'd0: begin p = sx * sy; return p; end
      3'd1: begin up = {32'h0, x} * {32'h0, y}; return up; end
      3'd2: begin
        if (y == 0) return {h, l};
        q = (sx < 0 ? -sx : sx) / (sy < 0 ? -sy : sy);
        if ((sx < 0) != (sy < 0)) q = -q;
        r = sx - q * sy;
        return {r[31:0], q[31:0]};
      end
      3'd3: return (y == 0) ? {h, l} : {x % y, x / y};
      3'd4: return {x, l};
      3'd5: return {h, x};
      default: return {h, l};
    endcase
  endfunction

  function automatic int exp_cycles(input logic [2:0] op);
    return op < 3'd2 ? 5 : op < 3'd4 ? 10 : 0;
  endfunction

  // Drive one op; count busy cycles, note if HI/LO moved while busy, optionally inject a stray MULT start
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, y, input int inj,
                        output int cyc, output bit moved);
    @(negedge clk);
    start = 1'b1; md_op = op; a = x; b = y;
    @(negedge clk);
    start = 1'b0; cyc = 0; moved = 1'b0;
    while (busy === 1'b1 && cyc < 60) begin
      if (hi !== ref_hi || lo !== ref_lo) moved = 1'b1;
      cyc++;
      if (cyc == inj) begin
        start = 1'b1; md_op = 3'd0; a = $urandom; b = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    int cyc;
    bit moved;
    logic [63:0] e;
    vectors++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_init busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd4, 32'haaaa, 32'h0, 0, cyc, moved);
    ref_hi = 32'haaaa;
    run_op(3'd5, 32'hbbbb, 32'h0, 0, cyc, moved);
    ref_lo = 32'hbbbb;
    @(negedge clk);
    start = 1'b1; md_op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre_busy busy=%b want 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_async busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    ref_hi = '0; ref_lo = '0;
    e = model(3'd0, 32'd6, 32'd7, ref_hi, ref_lo);
    run_op(3'd0, 32'd6, 32'd7, 0, cyc, moved);
    vectors++;
    if (cyc != 5 || {hi, lo} !== e || {hi, lo} !== 64'd42) begin
      miscompares++;
      $display("FAIL reset_after cyc=%0d hi=%h lo=%h want 5 %h", cyc, hi, lo, e);
    end
    {ref_hi, ref_lo} = e;
  endtask

  task automatic test_mult();
    int cyc;
    bit moved;
    run_op(3'd0, 32'hffff_fffe, 32'd3, 0, cyc, moved);
    vectors++;
    if (cyc != 5 || moved) begin
      miscompares++;
      $display("FAIL mult_busy cyc=%0d moved=%b want 5 0", cyc, moved);
    end
    vectors++;
    if (hi !== 32'hffff_ffff || lo !== 32'hffff_fffa) begin
      miscompares++;
      $display("FAIL mult_result hi=%h lo=%h want ffffffff fffffffa", hi, lo);
    end
    {ref_hi, ref_lo} = {hi === 32'hffff_ffff ? hi : 32'hffff_ffff, 32'hffff_fffa};
    run_op(3'd1, 32'hffff_ffff, 32'hffff_ffff, 0, cyc, moved);
    vectors++;
    if (cyc != 5 || moved || hi !== 32'hffff_fffe || lo !== 32'h1) begin
      miscompares++;
      $display("FAIL multu_result cyc=%0d moved=%b hi=%h lo=%h want 5 0 fffffffe 00000001", cyc, moved, hi, lo);
    end
    ref_hi = 32'hffff_fffe; ref_lo = 32'h1;
  endtask

  task automatic test_div();
    int cyc;
    bit moved;
    run_op(3'd2, -32'sd7, 32'd2, 0, cyc, moved);
    vectors++;
    if (cyc != 10 || moved || hi !== 32'hffff_ffff || lo !== 32'hffff_fffd) begin
      miscompares++;
      $display("FAIL div_neg cyc=%0d moved=%b hi=%h lo=%h want 10 0 ffffffff fffffffd", cyc, moved, hi, lo);
    end
    ref_hi = 32'hffff_ffff; ref_lo = 32'hffff_fffd;
    run_op(3'd3, 32'd7, 32'd0, 0, cyc, moved);
    vectors++;
    if (cyc != 10 || moved || hi !== 32'hffff_ffff || lo !== 32'hffff_fffd) begin
      miscompares++;
      $display("FAIL divu_zero cyc=%0d moved=%b hi=%h lo=%h want 10 0 ffffffff fffffffd", cyc, moved, hi, lo);
    end
    run_op(3'd2, 32'h8000_0000, 32'hffff_ffff, 0, cyc, moved);
    vectors++;
    if (cyc != 10 || hi !== 32'h0 || lo !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL div_ovf cyc=%0d hi=%h lo=%h want 10 00000000 80000000", cyc, hi, lo);
    end
    ref_hi = 32'h0; ref_lo = 32'h8000_0000;
  endtask

  task automatic test_mt();
    @(negedge clk);
    start = 1'b1; md_op = 3'd4; a = 32'h1234;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || hi !== 32'h1234 || lo !== ref_lo) begin
      miscompares++;
      $display("FAIL mthi busy=%b hi=%h lo=%h want 0 00001234 %h", busy, hi, lo, ref_lo);
    end
    md_op = 3'd5; a = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || hi !== 32'h1234 || lo !== 32'h5678) begin
      miscompares++;
      $display("FAIL mtlo busy=%b hi=%h lo=%h want 0 00001234 00005678", busy, hi, lo);
    end
    ref_hi = 32'h1234; ref_lo = 32'h5678;
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit moved;
    logic [63:0] e;
    e = model(3'd2, 32'd1000, -32'sd33, ref_hi, ref_lo);
    run_op(3'd2, 32'd1000, -32'sd33, 3, cyc, moved);
    vectors++;
    if (cyc != 10 || moved || {hi, lo} !== e) begin
      miscompares++;
      $display("FAIL busy_start cyc=%0d moved=%b hi=%h lo=%h want 10 0 %h", cyc, moved, hi, lo, e);
    end
    {ref_hi, ref_lo} = e;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || {hi, lo} !== e) begin
      miscompares++;
      $display("FAIL busy_start_after busy=%b hi=%h lo=%h want 0 %h", busy, hi, lo, e);
    end
  endtask

  task automatic test_random();
    int cyc;
    bit moved;
    logic [2:0] op;
    logic [31:0] x, y;
    logic [63:0] e;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'h0;
        1: begin x = 32'h8000_0000; y = 32'hffff_ffff; end
        2: y = 32'($urandom_range(1, 9));
        default: ;
      endcase
      e = model(op, x, y, ref_hi, ref_lo);
      run_op(op, x, y, 0, cyc, moved);
      vectors++;
      if (cyc != exp_cycles(op) || moved || {hi, lo} !== e) begin
        miscompares++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h cyc=%0d moved=%b hi=%h lo=%h want cyc=%0d %h",
                 i, op, x, y, cyc, moved, hi, lo, exp_cycles(op), e);
      end
      {ref_hi, ref_lo} = e;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
